// File: rtl/in_scan_ctrl.sv
// in_scan_ctrl: multi-channel debounce scheduler for the LE board digital inputs.
// One compare/increment unit is time-shared across CH synchronized inputs, one
// channel per prescaled scan tick. Debounced level changes are flagged as
// pending and drained through a one-deep valid/ready event register with a
// round-robin pick over pending channels.
module in_scan_ctrl #(
  parameter int CH       = 8,
  parameter int CNT_W    = 6,
  parameter int TICK_DIV = 100,
  localparam int PTR_W   = $clog2(CH),
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] thr,
  input  logic [CH-1:0]    in_i,
  output logic [CH-1:0]    lvl_o,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [PTR_W-1:0] evt_ch,
  output logic             evt_level
);

  // A threshold of zero behaves as one: a single differing visit qualifies.
  function automatic logic [CNT_W-1:0] thr_floor(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  logic [CH-1:0]    sync_p0;
  logic [CH-1:0]    sync_p1;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt [CH];
  logic [CH-1:0]    stable;
  logic [CH-1:0]    pending;
  logic             samp;
  logic             differ;
  logic [CNT_W:0]   cnt_inc;
  logic             qualify;
  logic [CH-1:0]    set_mask;
  logic [CH-1:0]    clr_mask;
  logic [PTR_W-1:0] last_grant;
  logic [PTR_W-1:0] sel;
  logic             found;
  logic             load;
  logic             grant;

  // Two-flop synchronizer on every raw input; only sync_p1 is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_i;
      sync_p1 <= sync_p0;
    end
  end

  // Scan prescaler: one tick every TICK_DIV enabled cycles, frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  assign tick = en && (presc == PW'(TICK_DIV - 1));

  // Shared compare/increment unit working on the channel under the scan pointer.
  assign samp     = sync_p1[ptr];
  assign differ   = samp ^ stable[ptr];
  assign cnt_inc  = {1'b0, cnt[ptr]} + {{CNT_W{1'b0}}, 1'b1};
  assign qualify  = tick && differ && (cnt_inc >= {1'b0, thr_floor(thr)});
  assign set_mask = qualify ? (CH'(1) << ptr) : '0;

  // Per-channel stability counters, debounced levels and scan pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
      stable <= '0;
      ptr    <= '0;
    end else if (tick) begin
      if (!differ) begin
        cnt[ptr] <= '0;
      end else if (qualify) begin
        cnt[ptr]    <= '0;
        stable[ptr] <= samp;
      end else begin
        cnt[ptr] <= cnt_inc[CNT_W-1:0];
      end
      ptr <= (ptr == PTR_W'(CH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  assign lvl_o = stable;

  // Round-robin search over pending channels starting just after the last grant.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      idx = (int'(last_grant) + i) % CH;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  assign load     = !evt_valid || evt_ready;
  assign grant    = load && found;
  assign clr_mask = grant ? (CH'(1) << sel) : '0;

  // Pending flags: a new qualification in the same cycle as a grant keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // One-deep event register; reloads on empty or on accept, allowing back-to-back transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      evt_level  <= 1'b0;
      last_grant <= PTR_W'(CH - 1);
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_ch     <= sel;
        evt_level  <= stable[sel];
        last_grant <= sel;
      end
    end
  end

endmodule

// File: tb/tb_in_scan_ctrl.sv
// Directed testbench for in_scan_ctrl with CH=4, TICK_DIV=2 (channel c is visited
// on cycle 2m after reset release when (m-1) mod 4 == c).
module tb_in_scan_ctrl;
  localparam int CH = 4;
  localparam int CNT_W = 6;
  localparam int TICK_DIV = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic [CNT_W-1:0] thr = '0;
  logic [CH-1:0]    in_i = '0;
  logic [CH-1:0]    lvl_o;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [1:0]       evt_ch;
  logic             evt_level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int x0 = 0;

  in_scan_ctrl #(.CH(CH), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .thr(thr), .in_i(in_i), .lvl_o(lvl_o),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_level(evt_level)
  );

  always #5 clk = ~clk;

  // Count completed transfers.
  always @(posedge clk) begin
    if (rst_n && evt_valid && evt_ready) xfer_cnt <= xfer_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_ch !== 2'd0) begin n_bad++; $display("FAIL rst_ch: got %0d want 0", evt_ch); end
    n_cmp++; if (evt_level !== 1'b0) begin n_bad++; $display("FAIL rst_level: got %b want 0", evt_level); end
    n_cmp++; if (lvl_o !== 4'b0000) begin n_bad++; $display("FAIL rst_lvl: got %b want 0000", lvl_o); end
  endtask

  task automatic test_rise();
    do_reset();
    thr = 6'd3; en = 1'b1; evt_ready = 1'b1; in_i = 4'b0010; x0 = xfer_cnt;
    step_to(19);
    n_cmp++; if (lvl_o !== 4'b0000) begin n_bad++; $display("FAIL rise_lvl_c19: got %b want 0000", lvl_o); end
    step_to(20);
    n_cmp++; if (lvl_o !== 4'b0010) begin n_bad++; $display("FAIL rise_lvl_c20: got %b want 0010", lvl_o); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rise_valid_c20: got %b want 0", evt_valid); end
    step_to(21);
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL rise_valid_c21: got %b want 1", evt_valid); end
    n_cmp++; if (evt_ch !== 2'd1) begin n_bad++; $display("FAIL rise_ch: got %0d want 1", evt_ch); end
    n_cmp++; if (evt_level !== 1'b1) begin n_bad++; $display("FAIL rise_level: got %b want 1", evt_level); end
    step_to(22);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rise_valid_c22: got %b want 0", evt_valid); end
    step_to(60);
    n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL rise_evt_count: got %0d want 1", xfer_cnt - x0); end
  endtask

  task automatic test_glitch();
    do_reset();
    thr = 6'd3; en = 1'b1; evt_ready = 1'b1; in_i = 4'b0100; x0 = xfer_cnt;
    step_to(10);
    in_i = 4'b0000;
    step_to(30);
    n_cmp++; if (lvl_o !== 4'b0000) begin n_bad++; $display("FAIL glitch_lvl: got %b want 0000", lvl_o); end
    n_cmp++; if (xfer_cnt - x0 !== 0) begin n_bad++; $display("FAIL glitch_evt_count: got %0d want 0", xfer_cnt - x0); end
    // Held change afterwards needs three fresh visits (38, 46, 54).
    in_i = 4'b0100;
    step_to(53);
    n_cmp++; if (lvl_o !== 4'b0000) begin n_bad++; $display("FAIL glitch_hold_c53: got %b want 0000", lvl_o); end
    step_to(54);
    n_cmp++; if (lvl_o !== 4'b0100) begin n_bad++; $display("FAIL glitch_hold_c54: got %b want 0100", lvl_o); end
    step_to(58);
    n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL glitch_hold_evts: got %0d want 1", xfer_cnt - x0); end
  endtask

  task automatic test_rr_backpressure();
    do_reset();
    thr = 6'd1; en = 1'b1; evt_ready = 1'b0; in_i = 4'b0001;
    step_to(11);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin n_bad++; $display("FAIL rr_first: got v=%b ch=%0d want v=1 ch=0", evt_valid, evt_ch); end
    in_i = 4'b1101;
    step_to(20);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_level !== 1'b1) begin n_bad++; $display("FAIL rr_held: got v=%b ch=%0d l=%b want v=1 ch=0 l=1", evt_valid, evt_ch, evt_level); end
    n_cmp++; if (lvl_o !== 4'b1101) begin n_bad++; $display("FAIL rr_lvl: got %b want 1101", lvl_o); end
    evt_ready = 1'b1;
    step_to(21);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_level !== 1'b1) begin n_bad++; $display("FAIL rr_second: got v=%b ch=%0d l=%b want v=1 ch=2 l=1", evt_valid, evt_ch, evt_level); end
    step_to(22);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_level !== 1'b1) begin n_bad++; $display("FAIL rr_third: got v=%b ch=%0d l=%b want v=1 ch=3 l=1", evt_valid, evt_ch, evt_level); end
    step_to(23);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drained: got %b want 0", evt_valid); end
    // Wrap-around: with ch1 granted last, pending {0,2} must yield 2 before 0.
    evt_ready = 1'b0; in_i = 4'b1011;
    step_to(30);
    in_i = 4'b1010;
    step_to(36);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_level !== 1'b1) begin n_bad++; $display("FAIL rrw_held: got v=%b ch=%0d l=%b want v=1 ch=1 l=1", evt_valid, evt_ch, evt_level); end
    n_cmp++; if (lvl_o !== 4'b1010) begin n_bad++; $display("FAIL rrw_lvl: got %b want 1010", lvl_o); end
    evt_ready = 1'b1;
    step_to(37);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_level !== 1'b0) begin n_bad++; $display("FAIL rrw_next: got v=%b ch=%0d l=%b want v=1 ch=2 l=0", evt_valid, evt_ch, evt_level); end
    step_to(38);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_level !== 1'b0) begin n_bad++; $display("FAIL rrw_wrap: got v=%b ch=%0d l=%b want v=1 ch=0 l=0", evt_valid, evt_ch, evt_level); end
    step_to(39);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rrw_drained: got %b want 0", evt_valid); end
  endtask

  task automatic test_set_wins();
    do_reset();
    thr = 6'd1; en = 1'b1; evt_ready = 1'b0; in_i = 4'b0011;
    step_to(10);
    in_i = 4'b0010;
    step_to(17);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin n_bad++; $display("FAIL sw_held: got v=%b ch=%0d want v=1 ch=1", evt_valid, evt_ch); end
    evt_ready = 1'b1;
    step_to(18);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_level !== 1'b1) begin n_bad++; $display("FAIL sw_first: got v=%b ch=%0d l=%b want v=1 ch=0 l=1", evt_valid, evt_ch, evt_level); end
    n_cmp++; if (lvl_o !== 4'b0010) begin n_bad++; $display("FAIL sw_lvl: got %b want 0010", lvl_o); end
    step_to(19);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_level !== 1'b0) begin n_bad++; $display("FAIL sw_second: got v=%b ch=%0d l=%b want v=1 ch=0 l=0", evt_valid, evt_ch, evt_level); end
    step_to(20);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL sw_drained: got %b want 0", evt_valid); end
  endtask

  task automatic test_thr_zero_enable();
    do_reset();
    thr = 6'd0; en = 1'b1; evt_ready = 1'b1; in_i = 4'b0100;
    step_to(5);
    n_cmp++; if (lvl_o !== 4'b0000) begin n_bad++; $display("FAIL t0_lvl_c5: got %b want 0000", lvl_o); end
    step_to(6);
    n_cmp++; if (lvl_o !== 4'b0100) begin n_bad++; $display("FAIL t0_lvl_c6: got %b want 0100", lvl_o); end
    step_to(7);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_level !== 1'b1) begin n_bad++; $display("FAIL t0_evt: got v=%b ch=%0d l=%b want v=1 ch=2 l=1", evt_valid, evt_ch, evt_level); end
    step_to(8);
    evt_ready = 1'b0; in_i = 4'b1101;
    step_to(18);
    en = 1'b0; in_i = 4'b1111;
    step_to(22);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_level !== 1'b1) begin n_bad++; $display("FAIL en_held: got v=%b ch=%0d l=%b want v=1 ch=3 l=1", evt_valid, evt_ch, evt_level); end
    evt_ready = 1'b1;
    step_to(23);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_level !== 1'b1) begin n_bad++; $display("FAIL en_drain: got v=%b ch=%0d l=%b want v=1 ch=0 l=1", evt_valid, evt_ch, evt_level); end
    step_to(24);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL en_drained: got %b want 0", evt_valid); end
    step_to(69);
    n_cmp++; if (lvl_o !== 4'b1101) begin n_bad++; $display("FAIL en_frozen: got %b want 1101", lvl_o); end
    en = 1'b1;
    step_to(70);
    n_cmp++; if (lvl_o !== 4'b1101) begin n_bad++; $display("FAIL en_resume_c70: got %b want 1101", lvl_o); end
    step_to(71);
    n_cmp++; if (lvl_o !== 4'b1111) begin n_bad++; $display("FAIL en_resume_c71: got %b want 1111", lvl_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    thr = 6'd1; en = 1'b1; evt_ready = 1'b0; in_i = 4'b0111;
    step_to(10);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || lvl_o !== 4'b0111) begin n_bad++; $display("FAIL rm_pre: got v=%b ch=%0d lvl=%b want v=1 ch=1 lvl=0111", evt_valid, evt_ch, lvl_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rm_async_valid: got %b want 0", evt_valid); end
    n_cmp++; if (lvl_o !== 4'b0000 || evt_ch !== 2'd0) begin n_bad++; $display("FAIL rm_async_state: got lvl=%b ch=%0d want lvl=0000 ch=0", lvl_o, evt_ch); end
    repeat (2) @(posedge clk);
    #1;
    in_i = 4'b0001; evt_ready = 1'b1; rst_n = 1'b1; cyc = 0; x0 = xfer_cnt;
    step_to(1);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stale: got %b want 0", evt_valid); end
    step_to(9);
    n_cmp++; if (lvl_o !== 4'b0000) begin n_bad++; $display("FAIL rm_lvl_c9: got %b want 0000", lvl_o); end
    step_to(10);
    n_cmp++; if (lvl_o !== 4'b0001) begin n_bad++; $display("FAIL rm_lvl_c10: got %b want 0001", lvl_o); end
    step_to(11);
    n_cmp++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_level !== 1'b1) begin n_bad++; $display("FAIL rm_evt: got v=%b ch=%0d l=%b want v=1 ch=0 l=1", evt_valid, evt_ch, evt_level); end
    step_to(40);
    n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL rm_evt_count: got %0d want 1", xfer_cnt - x0); end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_rr_backpressure();
    test_set_wins();
    test_thr_zero_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/in_scan_ctrl.md
Name: in_scan_ctrl

Overview:
- Multi-channel debounce scheduler for the LE board digital inputs.
- Time-shares one compare/increment unit across CH raw inputs on a prescaled scan tick.
- Keeps a debounced level vector for all channels.
- Reports each debounced level change as an event through a one-deep valid/ready output, using a round-robin arbiter over channels with pending events.

Parameters:
- CH, 8, number of input channels (2..32).
- CNT_W, 6, width of the per-channel stability counter and of the threshold port.
- TICK_DIV, 100, clock cycles per scan tick (>=1); one channel is serviced per tick.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; low freezes prescaler, scan pointer and counters.
- thr  input  CNT_W  debounce threshold in consecutive differing visits; 0 treated as 1.
- in_i  input  CH  raw asynchronous inputs.
- lvl_o  output  CH  debounced level vector.
- evt_valid  output  1  event available.
- evt_ready  input  1  consumer accepts event.
- evt_ch  output  $clog2(CH)  channel index of the event.
- evt_level  output  1  new debounced level of evt_ch.

Behaviour:
- Reset (async, rst_n low), all cleared:
  - synchronizers = 0, stable = 0, counters = 0, pending = 0;
  - scan pointer ptr = 0, prescaler = 0;
  - evt_valid = 0, evt_ch = 0, evt_level = 0, lvl_o = 0.
- Reset mid-operation discards all pending and in-flight events.
- Sync: each in_i bit passes through a 2-FF synchronizer (reset 0). Only sync[ch] is used downstream.
- Prescaler:
  - With en=1, counts 0..TICK_DIV-1.
  - tick = 1 for one cycle when count = TICK_DIV-1; count then wraps to 0.
  - With en=0, count is held and tick = 0.
- Scan step (on tick), for channel c = ptr:
  - sync[c] == stable[c]: cnt[c] <= 0.
  - Otherwise cnt[c] <= cnt[c]+1.
  - If cnt[c]+1 >= max(thr,1): stable[c] <= sync[c], cnt[c] <= 0, pending[c] <= 1.
  - ptr <= (ptr == CH-1) ? 0 : ptr+1.
  - Counter never exceeds thr. thr changes take effect at the next visit.
- lvl_o = stable; it updates the cycle after the qualifying tick.
- Per-channel visit period is CH*TICK_DIV cycles.
- Minimum latency from a stable input change to the lvl_o change:
  - 2 sync cycles plus thr visits;
  - the first visit is at most CH*TICK_DIV cycles away.
- Event output register:
  - Loads when evt_valid=0 or (evt_valid and evt_ready).
  - Selects the pending channel by round-robin: search starts at last_granted+1, wrapping; last_granted resets to CH-1, so channel 0 is first.
  - On load: evt_valid=1, evt_ch = selected, evt_level = stable[selected] at load time, pending[selected] cleared.
  - If nothing is pending on an accept, evt_valid drops to 0.
- Handshake: evt_ch and evt_level hold while evt_valid=1 and evt_ready=0. A transfer completes on any cycle where both are high. Zero-bubble back-to-back delivery is allowed.
- Simultaneous set and clear of pending[c] in the same cycle: set wins. The channel is reported again later with its current level.
- Multiple toggles of a channel while it is pending merge into one event carrying the latest level.
- An event can therefore report a level equal to the previously reported one (two toggles). The consumer must tolerate this.
- en=0 does not affect the event output path; pending events still drain.

Test Plan:
- Rising edge on one channel:
  - Setup: CH=4, TICK_DIV=2, thr=3, en=1, evt_ready=1.
  - Stimulus: in_i[1] 0->1 and hold.
  - Response: lvl_o[1] rises after the 3rd qualifying visit to channel 1 (visits 8 cycles apart); exactly one event, ch=1, level=1.
- Short glitch:
  - Setup as above.
  - Stimulus: in_i[2] high for 10 cycles, covering at most 2 visits.
  - Response: cnt resets, lvl_o unchanged, no event.
- Round-robin under backpressure:
  - Stimulus: evt_ready=0; channels 0, 2 and 3 all qualify.
  - Response: evt_valid=1 with ch=0, held stable. Then raise evt_ready: events ch=2 and ch=3 follow on consecutive cycles, then evt_valid=0.
- Set-wins collision:
  - Stimulus: channel 0 event being accepted in the same cycle its pending bit sets again (input toggled back).
  - Response: a second event for ch=0 appears with level=0.
- Threshold zero and enable:
  - Stimulus: thr=0.
  - Response: channel updates on its first differing visit.
  - Stimulus: en=0 for 50 cycles.
  - Response: ptr, prescaler and counters frozen; queued events still drain.
- Reset mid-operation:
  - Stimulus: rst_n low with evt_valid=1 and 2 pending events.
  - Response: immediately evt_valid=0, lvl_o=0. After release, no stale events; scanning restarts at ptr=0.
